// File: rtl/mp_add_seq_if.sv
// rtl/mp_add_seq_if.sv - request/result bundle between a controller and mp_add_seq
//
// Signals:
//   start  controller -> sequencer  request, accepted on an edge where ready=1
//   sub    controller -> sequencer  0 = A+B, 1 = A-B (sampled with start)
//   A, B   controller -> sequencer  W-bit operands (sampled with start)
//   ready  sequencer -> controller  idle and able to accept start
//   S      sequencer -> controller  W-bit result, valid from done onward
//   cout   sequencer -> controller  final carry out (sub: 1 = no borrow)
//   done   sequencer -> controller  one-cycle pulse marking S/cout valid
//   ovf    sequencer -> controller  signed overflow (only with MPADD_OVF_EN)
//
// Modports: master = controller side, slave = sequencer side.
// Build option: MPADD_OVF_EN adds the ovf signal.

interface mp_add_seq_if #(
  parameter int NWORDS = 4
);
  localparam int W = 16 * NWORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic [W-1:0] S;
  logic         cout;
  logic         done;
`ifdef MPADD_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, sub, A, B,
`ifdef MPADD_OVF_EN
    input  ovf,
`endif
    input  ready, S, cout, done
  );

  modport slave (
    input  start, sub, A, B,
`ifdef MPADD_OVF_EN
    output ovf,
`endif
    output ready, S, cout, done
  );

endinterface

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-precision add/subtract sequencer over one 16-bit ripple adder
//
// mp_add_seq performs an NWORDS x 16-bit add or subtract, one word per clock,
// least-significant word first, keeping the inter-word carry in a register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mp_add_seq_if.slave (start/sub/A/B in, ready/S/cout/done[/ovf] out)
//
// Parameters:
//   NWORDS  words per operand, 2..8; operand width W = 16*NWORDS
//
// Build option: MPADD_OVF_EN adds the signed overflow output bus.ovf.
//
// rca_16 is the shared 16-bit ripple-carry adder (A, B, cin -> S, cout).

module rca_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [16:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[16];
  end
endmodule

module mp_add_seq #(
  parameter int NWORDS = 4
) (
  input logic          clk,
  input logic          rst_n,
  mp_add_seq_if.slave  bus
);
  localparam int W  = 16 * NWORDS;
  localparam int IW = $clog2(NWORDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic          sub_q;
  logic [W-1:0]  a_q, b_q, s_q;
  logic          cout_q;
  logic          done_q;
`ifdef MPADD_OVF_EN
  logic          ovf_q;
`endif

  logic [15:0]   add_a, add_b, add_s;
  logic          add_cout;
  logic          accept;
  logic          last;

  // Subtraction is A + ~B + 1: B words are inverted and the carry register
  // is seeded with 1 at accept.
  assign add_a = a_q[idx_q*16 +: 16];
  assign add_b = sub_q ? ~b_q[idx_q*16 +: 16] : b_q[idx_q*16 +: 16];

  rca_16 u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );

  assign last = (idx_q == IW'(NWORDS - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MPADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        a_q     <= bus.A;
        b_q     <= bus.B;
        sub_q   <= bus.sub;
        carry_q <= bus.sub;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        s_q[idx_q*16 +: 16] <= add_s;
        carry_q             <= add_cout;
        idx_q               <= idx_q + 1'b1;
        if (last) begin
          cout_q <= add_cout;
          done_q <= 1'b1;
          idx_q  <= '0;
`ifdef MPADD_OVF_EN
          // Carry into the top bit is recovered from its sum bit.
          ovf_q  <= (add_a[15] ^ add_b[15] ^ add_s[15]) ^ add_cout;
`endif
        end
      end
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.S     = s_q;
  assign bus.cout  = cout_q;
  assign bus.done  = done_q;
`ifdef MPADD_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one instance of the team's 16-bit ripple-carry adder (RCA_16: A, B, cin -> S, cout).
- Performs an NWORDS x 16-bit addition or subtraction one word per clock, least-significant word first.
- Carry is held in a register between words.
- Sits between a requesting controller (start/ready/done handshake) and the shared adder datapath; lets the team do 64-bit arithmetic without widening the adder.

Parameters:
- NWORDS, 4, number of 16-bit words per operand (legal range 2..8); operand width W = 16*NWORDS.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only on a rising edge where ready=1.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- A  input  W  operand A; sampled with start.
- B  input  W  operand B; sampled with start.
- ready  output  1  high when idle and able to accept start.
- S  output  W  result; valid from done onward.
- cout  output  1  final carry out (for sub: 1 = no borrow).
- done  output  1  one-cycle pulse marking S/cout valid.

Behaviour:
- Reset (async assert, sync-to-clk deassert is the integrator's job):
  - state=IDLE, ready=1, done=0, S=0, cout=0.
  - Word index=0, carry register=0, operand registers=0.
- States are IDLE and RUN.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch A, B and sub; set index=0; carry register=sub; go to RUN; ready falls.
  - S and cout are not cleared at accept; S is overwritten word by word during RUN.
- RUN (ready=0):
  - Adder inputs each cycle: A word[index], B word[index] (bitwise inverted when sub=1), cin = carry register.
  - Each edge: S word[index] <= adder S; carry <= adder cout; index <= index+1.
  - On the edge that writes word NWORDS-1: cout <= adder cout; done <= 1; go to IDLE.
- Latency:
  - Start accepted on edge k; words written on edges k+1..k+NWORDS.
  - done is high for exactly the cycle after edge k+NWORDS; ready=1 in that same cycle.
  - Throughput is one operation per NWORDS+1 cycles with back-to-back starts.
- done is registered and deasserts on the next edge unconditionally.
- start while ready=0 is ignored; no queuing, no error flag.
- start held high continuously causes an immediate re-accept in the done cycle (back-to-back operation).
- S and cout hold their values from done until the first word of the next operation is written.
- Width rules:
  - S is W bits, modulo 2^W; cout is the carry out of bit W-1.
  - The index counter is ceil(log2(NWORDS)) bits; wrap-around never occurs because RUN exits at NWORDS-1.
- Reset mid-RUN: abort immediately; all outputs return to reset values; no done is issued.
- Operands changing on A/B/sub during RUN have no effect (only latched copies are used).

Optional Feature:
- Macro MPADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset value 0.
  - Updated on the final-word edge, together with cout, as the signed two's-complement overflow of the full W-bit operation: carry into bit W-1 XOR carry out of bit W-1.
  - Holds its value like S.
- Undefined: port ovf is absent; no overflow logic is generated.

Test Plan:
- NWORDS=4:
  - Stimulus: A=0x0000_0000_0000_FFFF, B=0x1, sub=0.
  - Required: S=0x0000_0000_0001_0000, cout=0, done pulses exactly 5 cycles after the accept edge.
- Carry chain:
  - Stimulus: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, sub=0.
  - Required: S=0, cout=1.
- Subtract:
  - Stimulus: A=5, B=7, sub=1.
  - Required: S=0xFFFF_FFFF_FFFF_FFFE, cout=0.
  - Then stimulus: A=7, B=5, sub=1.
  - Required: S=2, cout=1.
- Busy-ignore:
  - Stimulus: start pulsed with different operands 2 cycles into RUN.
  - Required: result matches the first operation only; exactly one done pulse; ready stays 0 until the done cycle.
- Reset mid-op:
  - Stimulus: rst_n driven low for 1 cycle during RUN (index=2).
  - Required: ready=1, S=0, cout=0 immediately; no done.
  - Then a new A=1, B=1 operation yields S=2.
- With MPADD_OVF_EN:
  - Stimulus: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0.
  - Required: S=0x8000_0000_0000_0000, ovf=1, cout=0.
  - Then stimulus: A=1, B=1.
  - Required: ovf=0.
